pc_fetch_sequencer: RTL

Instruction-fetch front end of the MIPS core: owns the program counter, issues word fetches to instruction memory over a request/grant/response handshake, and buffers returned instructions toward decode on a valid/ready interface. It is the consumer of the jump-target path: decode supplies a 32-bit jump address, built from `if_pc_plus_4[31:28]` and the shifted 26-bit target, and this block redirects fetch to it, discarding all younger work. No architectural branch delay slot: a redirect squashes everything fetched after the redirecting instruction.

---
 rtl/pc_fetch_sequencer_if.sv | 26 ++
 rtl/pc_fetch_sequencer.sv | 103 ++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-unit bus: instruction-memory request/grant/response, decode-side valid/ready,
// and the jump redirect from decode.
interface pc_fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus_4;
  logic        if_ready;
  logic        jump_valid;
  logic [31:0] jump_address;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus_4,
    input  imem_gnt, imem_rvalid, imem_rdata, if_ready, jump_valid, jump_address
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus_4,
    output imem_gnt, imem_rvalid, imem_rdata, if_ready, jump_valid, jump_address
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Instruction-fetch front end: owns the PC, issues credit-limited word fetches and
// buffers responses toward decode; a jump squashes all younger in-flight work.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
  parameter int unsigned BUF_DEPTH    = 4
) (
  input logic                  clk,
  input logic                  reset,
  pc_fetch_sequencer_if.master bus
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0]                 pc_q, pc_d;
  logic [BUF_DEPTH-1:0][31:0]  tag_q, instr_q, ipc_q;
  ptr_t                        tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  ptr_t                        buf_wp_q, buf_wp_d, buf_rp_q, buf_rp_d;
  cnt_t                        out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
  logic [CW+1:0]               used;
  logic                        grant, take, drop, pop, push;

  // Credits use registered counts only, so a pop frees its slot one cycle later.
  assign used = (CW+2)'(out_q) + (CW+2)'(disc_q) + (CW+2)'(cnt_q);
  assign bus.imem_req  = !reset && !bus.jump_valid && (used < (CW+2)'(BUF_DEPTH));
  assign bus.imem_addr = pc_q;

  assign grant = bus.imem_req && bus.imem_gnt;
  assign drop  = bus.imem_rvalid && (disc_q != '0);
  // A response with nothing outstanding and nothing to discard is ignored.
  assign take  = bus.imem_rvalid && (disc_q == '0) && (out_q != '0);
  assign pop   = (cnt_q != '0) && bus.if_ready;
  assign push  = take && !bus.jump_valid;

  assign bus.if_valid     = (cnt_q != '0);
  assign bus.if_instr     = instr_q[buf_rp_q];
  assign bus.if_pc        = ipc_q[buf_rp_q];
  assign bus.if_pc_plus_4 = ipc_q[buf_rp_q] + 32'd4;

  always_comb begin
    pc_d     = pc_q;
    tag_wp_d = tag_wp_q;
    tag_rp_d = tag_rp_q;
    buf_wp_d = buf_wp_q;
    buf_rp_d = buf_rp_q;
    out_d    = out_q;
    disc_d   = disc_q;
    cnt_d    = cnt_q;
    if (bus.jump_valid) begin
      pc_d     = bus.jump_address & ~32'h3;
      tag_wp_d = '0;
      tag_rp_d = '0;
      buf_wp_d = '0;
      buf_rp_d = '0;
      cnt_d    = '0;
      out_d    = '0;
      // Everything still outstanding becomes a discard, less a response taken now.
      disc_d   = disc_q - cnt_t'(drop) + out_q - cnt_t'(take);
    end else begin
      if (grant) begin
        pc_d     = pc_q + 32'd4;
        tag_wp_d = tag_wp_q + ptr_t'(1);
      end
      if (take) tag_rp_d = tag_rp_q + ptr_t'(1);
      if (push) buf_wp_d = buf_wp_q + ptr_t'(1);
      if (pop)  buf_rp_d = buf_rp_q + ptr_t'(1);
      out_d  = out_q + cnt_t'(grant) - cnt_t'(take);
      disc_d = disc_q - cnt_t'(drop);
      cnt_d  = cnt_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_VECTOR;
      tag_wp_q <= '0;
      tag_rp_q <= '0;
      buf_wp_q <= '0;
      buf_rp_q <= '0;
      out_q    <= '0;
      disc_q   <= '0;
      cnt_q    <= '0;
      tag_q    <= '0;
      instr_q  <= '0;
      ipc_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      tag_wp_q <= tag_wp_d;
      tag_rp_q <= tag_rp_d;
      buf_wp_q <= buf_wp_d;
      buf_rp_q <= buf_rp_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      cnt_q    <= cnt_d;
      if (grant) tag_q[tag_wp_q] <= pc_q;
      if (push) begin
        instr_q[buf_wp_q] <= bus.imem_rdata;
        ipc_q[buf_wp_q]   <= tag_q[tag_rp_q];
      end
    end
  end
endmodule
